mod4_down_timer: RTL

Programmable countdown timer built from a chain of base-4 (mod-4) digits. It decrements once per qualified `dec` strobe, ripples borrows from digit to digit, and signals expiry with a one-cycle `done` pulse. It is the decrementing counterpart of the team's incrementing mod-4 counter and serves as the timeout/interval source for lab control FSMs. An optional auto-reload mode makes it a periodic tick generator.

---
 rtl/mod4_down_timer_if.sv | 24 ++
 rtl/mod4_down_timer.sv | 105 ++++++++++
 2 files changed

// File: rtl/mod4_down_timer_if.sv
// Control/status bundle for mod4_down_timer: load/start/stop/dec in, count and flags out.
interface mod4_down_timer_if #(
    parameter int unsigned W = 6
);
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         stop;
    logic         dec;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         zero;

    modport master (
        output load, load_val, start, stop, dec,
        input  q, busy, done, zero
    );

    modport slave (
        input  load, load_val, start, stop, dec,
        output q, busy, done, zero
    );
endinterface

// File: rtl/mod4_down_timer.sv
// Countdown timer built from a chain of base-4 digits with borrow ripple,
// one-cycle expiry pulse and optional auto-reload for periodic ticks.
module mod4_down_timer #(
    parameter int unsigned DIGITS      = 3,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    mod4_down_timer_if.slave  bus
);
    localparam int unsigned W = 2 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] q_q, q_d;
    logic [W-1:0] reload_q, reload_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic         zero_q, zero_d;
    logic [W-1:0] q_dec;
    logic [W-1:0] q_next;
    logic         borrow;

    // Digit-wise decrement: a digit steps down only when every lower digit is 0.
    always_comb begin
        q_dec  = q_q;
        borrow = 1'b1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (borrow) begin
                q_dec[2*k +: 2] = q_q[2*k +: 2] - 2'd1;
            end
            borrow = borrow && (q_q[2*k +: 2] == 2'd0);
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        q_next   = bus.load ? bus.load_val : q_q;

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    q_d      = bus.load_val;
                    reload_d = bus.load_val;
                end
                if (bus.start && (q_next != '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.dec && (q_q != '0)) begin
                    if (q_q == W'(1)) begin
                        done_d = 1'b1;
                        if (AUTO_RELOAD) begin
                            q_d = reload_q;
                        end else begin
                            q_d     = '0;
                            state_d = DONE;
                        end
                    end else begin
                        q_d = q_dec;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        zero_d = (q_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            q_q      <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.zero = zero_q;
endmodule
